// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, counter-based debounce FSM,
// registered level/press/release/long-press outputs and a press counter.
module btn_debounce #(
  parameter logic [27:0] DEBOUNCE_CYC = 28'd2_000_000,
  parameter logic [27:0] LONG_CYC     = 28'd40_000_000,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  output logic        btn_level,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        long_pulse,
  output logic [15:0] press_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    LONG_HELD,
    DEB_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [27:0]            cnt_q, cnt_d;
  logic                   long_done_q, long_done_d;
  logic                   lvl_q, lvl_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;
  logic [15:0]            press_cnt_q, press_cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  // Shift the asynchronous pin through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, shared counter and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      lvl_q       <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      long_q      <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      lvl_q       <= lvl_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  // Next state; the counter restarts on every state change and pulses default low
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 28'd1;
    long_done_d = long_done_q;
    lvl_d       = lvl_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    long_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEBOUNCE_CYC - 28'd1) begin
          state_d     = HELD;
          cnt_d       = '0;
          lvl_d       = 1'b1;
          press_d     = 1'b1;
          press_cnt_d = press_cnt_q + 16'd1;
          long_done_d = 1'b0;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_CYC - 28'd1) begin
          state_d     = LONG_HELD;
          cnt_d       = '0;
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end
      LONG_HELD: begin
        // long pulse already issued for this press; just wait for release
        cnt_d = '0;
        if (!s) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (s) begin
          // release rejected; long timer restarts unless it already fired
          state_d = long_done_q ? LONG_HELD : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEBOUNCE_CYC - 28'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          lvl_d   = 1'b0;
          rel_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level     = lvl_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign press_cnt     = press_cnt_q;

endmodule
